// File: rtl/regfile_pkg.sv
// Shared sizing and typedefs for the 20-bit datapath register file.
// Decode and writeback use reg_addr_t/reg_data_t for selects and write data.
package regfile_pkg;
  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: NUM_REGS:1 mux over the storage array.
// Defining REGFILE_BYPASS_EN forwards same-cycle write data to a matching select.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int P_DATA_W   = DATA_W,
  parameter int P_ADDR_W   = ADDR_W,
  parameter int P_NUM_REGS = NUM_REGS
) (
  input  logic [P_NUM_REGS-1:0][P_DATA_W-1:0] regs,
  input  logic [P_ADDR_W-1:0]                 sel,
  input  logic                                wr_en,
  input  logic [P_ADDR_W-1:0]                 wr_addr,
  input  logic [P_DATA_W-1:0]                 wr_data,
  output logic [P_DATA_W-1:0]                 rd_data
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data = regs[sel];
    if (wr_en && (sel == wr_addr)) begin
      rd_data = wr_data;
    end
  end
`else
  // Write-side inputs only matter when forwarding is built in.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    rd_data = regs[sel];
  end
`endif

endmodule

// File: rtl/register_file.sv
// 16 x 20-bit register file: one synchronous write port, two combinational reads.
// Optional write-to-read forwarding is enabled with the REGFILE_BYPASS_EN macro.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Dest,
  input  logic [DATA_W-1:0] Data,
  input  logic [ADDR_W-1:0] Reg1,
  input  logic [ADDR_W-1:0] Reg2,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic                            wr_active;

  // Reset wins over a coincident write; register 0 is an ordinary register.
  always_comb begin
    regs_d = regs_q;
    if (!Reset) begin
      regs_d = '0;
    end else if (RW) begin
      regs_d[Dest] = Data;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign wr_active = RW && Reset;

  rf_read_port #(
    .P_DATA_W   (DATA_W),
    .P_ADDR_W   (ADDR_W),
    .P_NUM_REGS (NUM_REGS)
  ) u_read_port1 (
    .regs    (regs_q),
    .sel     (Reg1),
    .wr_en   (wr_active),
    .wr_addr (Dest),
    .wr_data (Data),
    .rd_data (out_reg1)
  );

  rf_read_port #(
    .P_DATA_W   (DATA_W),
    .P_ADDR_W   (ADDR_W),
    .P_NUM_REGS (NUM_REGS)
  ) u_read_port2 (
    .regs    (regs_q),
    .sel     (Reg2),
    .wr_en   (wr_active),
    .wr_addr (Dest),
    .wr_data (Data),
    .rd_data (out_reg2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array model checked every cycle plus
// hand-computed literal expectations; also valid with REGFILE_BYPASS_EN defined.
module tb_register_file;

  logic        clk;
  logic        Reset;
  logic        RW;
  logic [3:0]  Dest;
  logic [19:0] Data;
  logic [3:0]  Reg1;
  logic [3:0]  Reg2;
  logic [19:0] out_reg1;
  logic [19:0] out_reg2;

  logic [19:0] model [16];
  logic        checking;
  int          total;
  int          bad;

  register_file dut (
    .clk      (clk),
    .Reset    (Reset),
    .RW       (RW),
    .Dest     (Dest),
    .Data     (Data),
    .Reg1     (Reg1),
    .Reg2     (Reg2),
    .out_reg1 (out_reg1),
    .out_reg2 (out_reg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [19:0] actual, input logic [19:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%05h expected 0x%05h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic rw, input logic [3:0] dest,
                               input logic [19:0] data, input logic [3:0] r1, input logic [3:0] r2);
    Reset = rst_n;
    RW    = rw;
    Dest  = dest;
    Data  = data;
    Reg1  = r1;
    Reg2  = r2;
    #1;
  endtask

  // Expected read value: stored contents, or the write data when forwarding applies.
  function automatic logic [19:0] expectedRead(input logic [3:0] sel);
    logic [19:0] v;
    v = model[sel];
    if (BYPASS && RW && Reset && (sel == Dest)) v = Data;
    return v;
  endfunction

  // Compare on the falling edge, then advance the model across the next rising edge.
  task automatic stepCycle();
    @(negedge clk);
    if (checking) begin
      checkOutput("model_r1", out_reg1, expectedRead(Reg1));
      checkOutput("model_r2", out_reg2, expectedRead(Reg2));
    end
    if (!Reset) begin
      for (int i = 0; i < 16; i++) model[i] = 20'h0;
      checking = 1'b1;
    end else if (RW) begin
      model[Dest] = Data;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    checking = 1'b0;
    Reset = 1'b0; RW = 1'b0; Dest = '0; Data = '0; Reg1 = '0; Reg2 = '0;
    @(posedge clk);
    #2;

    applyStimulus(1'b0, 1'b0, 4'd0, 20'h0, 4'd0, 4'd0);
    stepCycle();

    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'(n), 4'(15 - n));
      checkOutput("reset_r1", out_reg1, 20'h00000);
      checkOutput("reset_r2", out_reg2, 20'h00000);
      stepCycle();
    end

    applyStimulus(1'b1, 1'b1, 4'd5, 20'h00056, 4'd5, 4'd6);
    checkOutput("wr_pre_edge", out_reg1, BYPASS ? 20'h00056 : 20'h00000);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4'd5, 20'h00057, 4'd5, 4'd6);
    checkOutput("basic_wr_r1", out_reg1, 20'h00056);
    checkOutput("basic_wr_r2", out_reg2, 20'h00000);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'd5, 4'd6);
    checkOutput("wr_disabled", out_reg1, 20'h00056);
    stepCycle();

    applyStimulus(1'b0, 1'b1, 4'd5, 20'h00057, 4'd5, 4'd6);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'd5, 4'd6);
    checkOutput("rst_priority", out_reg1, 20'h00000);
    stepCycle();

    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, 1'b1, 4'(n), 20'hFFFF0 | 20'(n), 4'd0, 4'd15);
      stepCycle();
    end
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'(n), 4'(15 - n));
      checkOutput("range_r1", out_reg1, 20'hFFFF0 | 20'(n));
      checkOutput("range_r2", out_reg2, 20'hFFFF0 | 20'(15 - n));
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'd15, 4'd0);
    checkOutput("reg15_top", out_reg1, 20'hFFFFF);
    checkOutput("reg0_low", out_reg2, 20'hFFFF0);
    stepCycle();

    applyStimulus(1'b1, 1'b1, 4'd2, 20'h12345, 4'd0, 4'd3);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 4'd2, 20'hABCDE, 4'd2, 4'd3);
    checkOutput("rw_same_pre", out_reg1, BYPASS ? 20'hABCDE : 20'h12345);
    checkOutput("rw_other_port", out_reg2, 20'hFFFF3);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'd2, 4'd2);
    checkOutput("rw_same_post1", out_reg1, 20'hABCDE);
    checkOutput("rw_same_post2", out_reg2, 20'hABCDE);
    stepCycle();

    // Random traffic with occasional mid-run resets, checked only by the model.
    for (int k = 0; k < 200; k++) begin
      applyStimulus(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 20'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      stepCycle();
    end

    applyStimulus(1'b0, 1'b1, 4'd9, 20'h77777, 4'd9, 4'd9);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4'd0, 20'h0, 4'd9, 4'd0);
    checkOutput("mid_reset", out_reg1, 20'h00000);
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
